// File: rtl/cache_line_fill_engine_pkg.sv
// Shared types and constants for the cache line fill engine.
// Build option: CRIT_WORD_FIRST_EN selects critical-word-first WRAP bursts.
package kuuga_fill_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } fill_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP = 2'b10;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Clear the low lsb bits of an address.
  function automatic logic [63:0] line_align(
    input logic [63:0] addr,
    input int unsigned lsb
  );
    return (addr >> lsb) << lsb;
  endfunction

endpackage

// File: rtl/cache_line_fill_engine_if.sv
// Cache-side miss/fill handshake plus the AXI4 read channels.
// Build option: CRIT_WORD_FIRST_EN adds the critical-word strobe.
interface cache_line_fill_engine_if #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
);

  logic                         miss_valid;
  logic                         miss_ready;
  logic [ADDR_W-1:0]            miss_addr;
  logic                         fill_valid;
  logic                         fill_ready;
  logic [ADDR_W-1:0]            fill_addr;
  logic [LINE_WORDS*DATA_W-1:0] fill_data;
  logic                         fill_err;
  logic                         m_axi_arvalid;
  logic                         m_axi_arready;
  logic [ADDR_W-1:0]            m_axi_araddr;
  logic [7:0]                   m_axi_arlen;
  logic [2:0]                   m_axi_arsize;
  logic [1:0]                   m_axi_arburst;
  logic                         m_axi_rvalid;
  logic                         m_axi_rready;
  logic [DATA_W-1:0]            m_axi_rdata;
  logic [1:0]                   m_axi_rresp;
  logic                         m_axi_rlast;
`ifdef CRIT_WORD_FIRST_EN
  logic                         crit_valid;
  logic [DATA_W-1:0]            crit_data;
`endif

  // Engine view.
  modport master (
    input  miss_valid, miss_addr, fill_ready,
    output miss_ready,
    output fill_valid, fill_addr, fill_data, fill_err,
    output m_axi_arvalid, m_axi_araddr, m_axi_arlen,
    output m_axi_arsize, m_axi_arburst,
    input  m_axi_arready,
    input  m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    input  m_axi_rlast,
`ifdef CRIT_WORD_FIRST_EN
    output crit_valid, crit_data,
`endif
    output m_axi_rready
  );

  // Cache and memory view.
  modport slave (
    output miss_valid, miss_addr, fill_ready,
    input  miss_ready,
    input  fill_valid, fill_addr, fill_data, fill_err,
    input  m_axi_arvalid, m_axi_araddr, m_axi_arlen,
    input  m_axi_arsize, m_axi_arburst,
    output m_axi_arready,
    output m_axi_rvalid, m_axi_rdata, m_axi_rresp,
    output m_axi_rlast,
`ifdef CRIT_WORD_FIRST_EN
    input  crit_valid, crit_data,
`endif
    input  m_axi_rready
  );

endinterface

// File: rtl/cache_line_fill_engine_line_buffer.sv
// Line assembly buffer: one register per word, indexed write.
// Cleared on reset and at the start of every fill.
module fill_line_buffer #(
  parameter int LINE_WORDS = 4,
  parameter int DATA_W     = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          we,
  input  logic [$clog2(LINE_WORDS)-1:0] idx,
  input  logic [DATA_W-1:0]             wdata,
  output logic [LINE_WORDS*DATA_W-1:0]  line
);

  logic [DATA_W-1:0] mem [LINE_WORDS];

  // Word storage; clear wins over write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINE_WORDS; i++)
        mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < LINE_WORDS; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  for (genvar g = 0; g < LINE_WORDS; g++) begin : g_flat
    assign line[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: rtl/cache_line_fill_engine.sv
// One-miss line fill engine: cache miss -> AXI4 read burst -> line.
// Build option: CRIT_WORD_FIRST_EN (WRAP burst, critical word first).
module cache_line_fill_engine
  import kuuga_fill_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input logic clk,
  input logic rst_n,
  cache_line_fill_engine_if.master bus
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int WB    = $clog2(DATA_W / 8);
  localparam int LSB   = WB + CNT_W;

  fill_state_t       state;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt;
  logic              err;
  logic              miss_ready_q;
  logic              arvalid_q;
  logic              rready_q;
  logic              fill_valid_q;
  logic              accept;
  logic              beat;
  logic              last;
  logic [CNT_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] line_addr;

  assign accept = miss_ready_q && bus.miss_valid;
  assign beat   = (state == DATA) && rready_q
                  && bus.m_axi_rvalid;
  assign last   = (cnt == CNT_W'(LINE_WORDS - 1));

  assign line_addr =
    ADDR_W'(line_align(64'(addr_q), LSB));

`ifdef CRIT_WORD_FIRST_EN
  logic              crit_valid_q;
  logic [DATA_W-1:0] crit_data_q;

  assign wr_idx = cnt + addr_q[WB +: CNT_W];
  assign bus.m_axi_araddr =
    ADDR_W'(line_align(64'(addr_q), WB));
  assign bus.m_axi_arburst = AXI_BURST_WRAP;
  assign bus.crit_valid    = crit_valid_q;
  assign bus.crit_data     = crit_data_q;
`else
  assign wr_idx = cnt;
  assign bus.m_axi_araddr  = line_addr;
  assign bus.m_axi_arburst = AXI_BURST_INCR;
`endif

  assign bus.m_axi_arlen  = 8'(LINE_WORDS - 1);
  assign bus.m_axi_arsize = 3'(WB);
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready_q;
  assign bus.miss_ready    = miss_ready_q;
  assign bus.fill_valid    = fill_valid_q;
  assign bus.fill_addr     = line_addr;
  assign bus.fill_err      = err;

  fill_line_buffer #(
    .LINE_WORDS (LINE_WORDS),
    .DATA_W     (DATA_W)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .we    (beat),
    .idx   (wr_idx),
    .wdata (bus.m_axi_rdata),
    .line  (bus.fill_data)
  );

  // Fill sequencer with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      cnt          <= '0;
      err          <= 1'b0;
      miss_ready_q <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      fill_valid_q <= 1'b0;
`ifdef CRIT_WORD_FIRST_EN
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
`endif
    end else begin
`ifdef CRIT_WORD_FIRST_EN
      crit_valid_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (accept) begin
            addr_q       <= bus.miss_addr;
            miss_ready_q <= 1'b0;
            arvalid_q    <= 1'b1;
            state        <= ADDR;
          end else begin
            miss_ready_q <= 1'b1;
          end
        end
        ADDR: begin
          if (bus.m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            cnt <= cnt + 1'b1;
            if (bus.m_axi_rresp != AXI_RESP_OKAY)
              err <= 1'b1;
`ifdef CRIT_WORD_FIRST_EN
            if (cnt == '0) begin
              crit_valid_q <= 1'b1;
              crit_data_q  <= bus.m_axi_rdata;
            end
`endif
            // Leave on the last beat or an early RLAST;
            // any RLAST disagreement marks the fill bad.
            if (last || bus.m_axi_rlast) begin
              if (last != bus.m_axi_rlast)
                err <= 1'b1;
              rready_q     <= 1'b0;
              fill_valid_q <= 1'b1;
              state        <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.fill_ready) begin
            fill_valid_q <= 1'b0;
            err          <= 1'b0;
            cnt          <= '0;
            miss_ready_q <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_fill_engine.sv
// Directed, table-driven bench for cache_line_fill_engine.
// Build option: CRIT_WORD_FIRST_EN switches to the WRAP sequence.
module tb_cache_line_fill_engine;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cache_line_fill_engine_if #(
    .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)
  ) bus ();

  cache_line_fill_engine #(
    .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [31:0]  base;
    int           err_beat;
    int           last_beat;
    int           ar_dly;
    int           fr_dly;
    bit           hold_miss;
    logic [31:0]  exp_araddr;
    logic [1:0]   exp_burst;
    logic [127:0] exp_data;
    logic         exp_err;
  } vec_t;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic run_fill(input vec_t v);
    int nb;
    int t;
    logic ok;
    logic [127:0] d0;
    nb = (v.last_beat < LW) ? v.last_beat + 1 : LW;
    bus.miss_valid = 1'b1;
    bus.miss_addr  = v.addr;
    t = 0;
    while (!bus.miss_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("miss_ready", bus.miss_ready, 1);
    @(negedge clk);
    bus.miss_valid = 1'b0;
    bus.miss_addr  = '0;
    chk("ar_latency", bus.m_axi_arvalid, 1);
    chk("araddr", bus.m_axi_araddr, v.exp_araddr);
    chk("arlen", bus.m_axi_arlen, 3);
    chk("arsize", bus.m_axi_arsize, 2);
    chk("arburst", bus.m_axi_arburst, v.exp_burst);
    if (v.ar_dly > 0) begin
      ok = 1'b1;
      repeat (v.ar_dly) begin
        @(negedge clk);
        if (!bus.m_axi_arvalid ||
            bus.m_axi_araddr != v.exp_araddr ||
            bus.m_axi_arlen != 8'd3)
          ok = 1'b0;
      end
      chk("ar_stable", ok, 1);
    end
    bus.m_axi_arready = 1'b1;
    @(negedge clk);
    bus.m_axi_arready = 1'b0;
    chk("ar_single", bus.m_axi_arvalid, 0);
    chk("rready", bus.m_axi_rready, 1);
    for (int k = 0; k < nb; k++) begin
      bus.m_axi_rvalid = 1'b1;
      bus.m_axi_rdata  = v.base + 32'(k);
      bus.m_axi_rresp  = (k == v.err_beat) ? 2'b10 : 2'b00;
      bus.m_axi_rlast  = (k == v.last_beat);
      @(negedge clk);
`ifdef CRIT_WORD_FIRST_EN
      if (k == 0) begin
        chk("crit_valid", bus.crit_valid, 1);
        chk("crit_data", bus.crit_data, v.base);
      end else if (k == 1) begin
        chk("crit_pulse", bus.crit_valid, 0);
      end
`endif
    end
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rlast  = 1'b0;
    bus.m_axi_rresp  = 2'b00;
    chk("fill_latency", bus.fill_valid, 1);
    chk("rready_off", bus.m_axi_rready, 0);
    if (v.hold_miss) begin
      bus.miss_valid = 1'b1;
      bus.miss_addr  = 32'h0000_5000;
    end
    if (v.fr_dly > 0) begin
      ok = 1'b1;
      d0 = bus.fill_data;
      repeat (v.fr_dly) begin
        @(negedge clk);
        if (!bus.fill_valid || bus.fill_data !== d0 ||
            bus.miss_ready)
          ok = 1'b0;
      end
      chk("fill_hold", ok, 1);
    end
    bus.miss_valid = 1'b0;
    bus.miss_addr  = '0;
    bus.fill_ready = 1'b1;
    chk("fill_data", bus.fill_data, v.exp_data);
    chk("fill_addr", bus.fill_addr,
        v.exp_araddr & 32'hFFFF_FFF0);
    chk("fill_err", bus.fill_err, v.exp_err);
    @(negedge clk);
    bus.fill_ready = 1'b0;
    chk("fill_done", bus.fill_valid, 0);
    chk("idle_ready", bus.miss_ready, 1);
  endtask

  initial begin
    vec_t tbl[8];
    vec_t cv;
    rst_n             = 1'b0;
    bus.miss_valid    = 1'b0;
    bus.miss_addr     = '0;
    bus.fill_ready    = 1'b0;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;

    tbl[0] = '{32'h0000_0104, 32'h40, -1, 3, 0, 0, 0,
      32'h0000_0100, 2'b01,
      128'h00000043_00000042_00000041_00000040, 1'b0};
    tbl[1] = '{32'h2000_0038, 32'h100, -1, 3, 5, 0, 0,
      32'h2000_0030, 2'b01,
      128'h00000103_00000102_00000101_00000100, 1'b0};
    tbl[2] = '{32'h0000_0050, 32'h200, 2, 3, 0, 0, 0,
      32'h0000_0050, 2'b01,
      128'h00000203_00000202_00000201_00000200, 1'b1};
    tbl[3] = '{32'h0000_0060, 32'h300, -1, 3, 0, 0, 0,
      32'h0000_0060, 2'b01,
      128'h00000303_00000302_00000301_00000300, 1'b0};
    tbl[4] = '{32'h0000_0074, 32'h400, -1, 1, 0, 0, 0,
      32'h0000_0070, 2'b01,
      128'h00000000_00000000_00000401_00000400, 1'b1};
    tbl[5] = '{32'h0000_008C, 32'h500, -1, 3, 0, 10, 1,
      32'h0000_0080, 2'b01,
      128'h00000503_00000502_00000501_00000500, 1'b0};
    tbl[6] = '{32'h0000_009F, 32'h600, -1, 99, 0, 0, 0,
      32'h0000_0090, 2'b01,
      128'h00000603_00000602_00000601_00000600, 1'b1};
    tbl[7] = '{32'hFFFF_FFFC, 32'h700, 0, 3, 0, 0, 0,
      32'hFFFF_FFF0, 2'b01,
      128'h00000703_00000702_00000701_00000700, 1'b1};

    repeat (3) @(negedge clk);
    chk("rst_miss_ready", bus.miss_ready, 0);
    chk("rst_arvalid", bus.m_axi_arvalid, 0);
    chk("rst_rready", bus.m_axi_rready, 0);
    chk("rst_fill_valid", bus.fill_valid, 0);
    chk("rst_fill_err", bus.fill_err, 0);
    chk("rst_fill_data", bus.fill_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifndef CRIT_WORD_FIRST_EN
    for (int i = 0; i < 8; i++)
      run_fill(tbl[i]);
`else
    cv = '{32'h0000_010C, 32'h40, -1, 3, 0, 0, 0,
      32'h0000_010C, 2'b10,
      128'h00000040_00000043_00000042_00000041, 1'b0};
    run_fill(cv);
`endif

    // Reset in the middle of a burst.
    bus.miss_valid = 1'b1;
    bus.miss_addr  = 32'h0000_0200;
    @(negedge clk);
    bus.miss_valid    = 1'b0;
    bus.m_axi_arready = 1'b1;
    @(negedge clk);
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b1;
    bus.m_axi_rdata   = 32'h0000_00AA;
    repeat (2) @(negedge clk);
    chk("mid_rready", bus.m_axi_rready, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rready", bus.m_axi_rready, 0);
    chk("mid_rst_arvalid", bus.m_axi_arvalid, 0);
    chk("mid_rst_fill_valid", bus.fill_valid, 0);
    chk("mid_rst_miss_ready", bus.miss_ready, 0);
    chk("mid_rst_fill_err", bus.fill_err, 0);
    chk("mid_rst_fill_data", bus.fill_data, 0);
    bus.m_axi_rvalid = 1'b0;
    bus.m_axi_rdata  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", bus.miss_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

endmodule
